// File: rtl/player_pos_ctl.sv
// Player sprite position controller: synchronises the keyboard direction levels,
// then moves the sprite once per frame with speed ramp-up and clamping to the visible area.
module player_pos_ctl #(
    parameter int HOR_PIXELS = 1024,
    parameter int VER_PIXELS = 768,
    parameter int SPRITE_W   = 32,
    parameter int SPRITE_H   = 32,
    parameter int X_INIT     = 496,
    parameter int Y_INIT     = 368,
    parameter int STEP_MAX   = 4,
    parameter int ACC_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vblnk,
    input  logic        move_up,
    input  logic        move_down,
    input  logic        move_left,
    input  logic        move_right,
    output logic [11:0] xpos,
    output logic [11:0] ypos,
    output logic        moving
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CALC   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam logic signed [13:0] X_MAX     = 14'(HOR_PIXELS - SPRITE_W);
    localparam logic signed [13:0] Y_MAX     = 14'(VER_PIXELS - SPRITE_H);
    localparam logic [3:0]         SPEED_MAX = 4'(STEP_MAX);
    localparam logic [7:0]         ACC_LAST  = 8'(ACC_FRAMES - 1);

    // Direction vectors are packed as {up, down, left, right}.
    logic [3:0]  r_dir_meta;
    logic [3:0]  r_dir_sync;
    logic        r_vblnk_q;
    logic [1:0]  r_state;
    logic        r_go_up;
    logic        r_go_down;
    logic        r_go_left;
    logic        r_go_right;
    logic [11:0] r_cand_x;
    logic [11:0] r_cand_y;
    logic [11:0] r_xpos;
    logic [11:0] r_ypos;
    logic        r_moving;
    logic [3:0]  r_speed;
    logic [7:0]  r_acc;

    logic        w_frame;
    logic        w_up;
    logic        w_down;
    logic        w_left;
    logic        w_right;
    logic        w_any_move;
    logic [11:0] w_cand_x;
    logic [11:0] w_cand_y;

    // One signed step along an axis, then clamp; the extra headroom bit keeps
    // positions near the top of the 12-bit range from wrapping.
    function automatic logic [11:0] step_clamp(
        input logic [11:0]        pos,
        input logic               inc,
        input logic               dec,
        input logic [3:0]         step,
        input logic signed [13:0] lim
    );
        logic signed [13:0] sum;
        logic [11:0]        res;
        sum = $signed({2'b00, pos});
        if (inc) begin
            sum = sum + $signed({10'd0, step});
        end else if (dec) begin
            sum = sum - $signed({10'd0, step});
        end
        if (sum < 0) begin
            res = 12'd0;
        end else if (sum > lim) begin
            res = lim[11:0];
        end else begin
            res = sum[11:0];
        end
        return res;
    endfunction

    assign w_frame = vblnk & ~r_vblnk_q;

    // Opposing keys cancel each other.
    assign w_up    = r_dir_sync[3] & ~r_dir_sync[2];
    assign w_down  = r_dir_sync[2] & ~r_dir_sync[3];
    assign w_left  = r_dir_sync[1] & ~r_dir_sync[0];
    assign w_right = r_dir_sync[0] & ~r_dir_sync[1];

    assign w_cand_x = step_clamp(r_xpos, w_right, w_left, r_speed, X_MAX);
    assign w_cand_y = step_clamp(r_ypos, w_down,  w_up,   r_speed, Y_MAX);

    assign w_any_move = r_go_up | r_go_down | r_go_left | r_go_right;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dir_meta <= 4'd0;
            r_dir_sync <= 4'd0;
            r_vblnk_q  <= 1'b0;
            r_state    <= ST_IDLE;
            r_go_up    <= 1'b0;
            r_go_down  <= 1'b0;
            r_go_left  <= 1'b0;
            r_go_right <= 1'b0;
            r_cand_x   <= 12'(X_INIT);
            r_cand_y   <= 12'(Y_INIT);
            r_xpos     <= 12'(X_INIT);
            r_ypos     <= 12'(Y_INIT);
            r_moving   <= 1'b0;
            r_speed    <= 4'd1;
            r_acc      <= 8'd0;
        end else begin
            r_dir_meta <= {move_up, move_down, move_left, move_right};
            r_dir_sync <= r_dir_meta;
            r_vblnk_q  <= vblnk;
            case (r_state)
                ST_IDLE: begin
                    if (w_frame) begin
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    r_go_up    <= w_up;
                    r_go_down  <= w_down;
                    r_go_left  <= w_left;
                    r_go_right <= w_right;
                    r_cand_x   <= w_cand_x;
                    r_cand_y   <= w_cand_y;
                    r_state    <= ST_COMMIT;
                end
                ST_COMMIT: begin
                    r_xpos   <= r_cand_x;
                    r_ypos   <= r_cand_y;
                    r_moving <= (r_cand_x != r_xpos) || (r_cand_y != r_ypos);
                    // Held direction ramps speed even when pinned against a clamp.
                    if (w_any_move) begin
                        if (r_acc == ACC_LAST) begin
                            r_acc <= 8'd0;
                            if (r_speed < SPEED_MAX) begin
                                r_speed <= r_speed + 4'd1;
                            end
                        end else begin
                            r_acc <= r_acc + 8'd1;
                        end
                    end else begin
                        r_speed <= 4'd1;
                        r_acc   <= 8'd0;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign xpos   = r_xpos;
    assign ypos   = r_ypos;
    assign moving = r_moving;

endmodule

// File: tb/tb_player_pos_ctl.sv
// Self-checking bench for player_pos_ctl: directed scenarios plus randomized frames
// compared against a per-frame arithmetic model of sprite motion.
module tb_player_pos_ctl;

    localparam int XMAX  = 1024 - 32;
    localparam int YMAX  = 768 - 32;
    localparam int STEPM = 4;
    localparam int ACCF  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vblnk = 1'b0;
    logic        mu = 1'b0;
    logic        md = 1'b0;
    logic        ml = 1'b0;
    logic        mr = 1'b0;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        moving;

    int   n_checks = 0;
    int   n_pass = 0;
    int   m_x;
    int   m_y;
    int   m_speed;
    int   m_acc;
    logic m_moving;

    always #5 clk = ~clk;

    player_pos_ctl #(
        .HOR_PIXELS(1024), .VER_PIXELS(768), .SPRITE_W(32), .SPRITE_H(32),
        .X_INIT(496), .Y_INIT(368), .STEP_MAX(STEPM), .ACC_FRAMES(ACCF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vblnk(vblnk),
        .move_up(mu), .move_down(md), .move_left(ml), .move_right(mr),
        .xpos(xpos), .ypos(ypos), .moving(moving)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_x = 496; m_y = 368; m_speed = 1; m_acc = 0; m_moving = 1'b0;
    endtask

    // One frame of motion: move by the current speed, clamp, then ramp speed.
    task automatic model_frame(input logic u, input logic d, input logic l, input logic r);
        int dx, dy, nx, ny;
        dx = (r && !l) ? 1 : ((l && !r) ? -1 : 0);
        dy = (d && !u) ? 1 : ((u && !d) ? -1 : 0);
        nx = m_x + dx * m_speed;
        ny = m_y + dy * m_speed;
        nx = (nx < 0) ? 0 : ((nx > XMAX) ? XMAX : nx);
        ny = (ny < 0) ? 0 : ((ny > YMAX) ? YMAX : ny);
        m_moving = (nx != m_x) || (ny != m_y);
        m_x = nx;
        m_y = ny;
        if (dx != 0 || dy != 0) begin
            m_acc++;
            if (m_acc == ACCF) begin
                m_acc = 0;
                if (m_speed < STEPM) m_speed++;
            end
        end else begin
            m_speed = 1;
            m_acc = 0;
        end
    endtask

    task automatic set_dirs(input logic u, input logic d, input logic l, input logic r);
        mu = u; md = d; ml = l; mr = r;
    endtask

    task automatic run_frame(input logic u, input logic d, input logic l, input logic r, input int plen);
        set_dirs(u, d, l, r);
        repeat (4) tick();
        vblnk = 1'b1;
        repeat (plen) tick();
        vblnk = 1'b0;
        repeat (5) tick();
        model_frame(u, d, l, r);
        $display("frame u%0b d%0b l%0b r%0b vblnk_len=%0d -> xpos=%0d ypos=%0d moving=%0b",
                 u, d, l, r, plen, xpos, ypos, moving);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        vblnk = 1'b0;
        set_dirs(0, 0, 0, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        model_reset();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_dirs(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            vblnk = (i % 2 == 0);
            tick();
            n_checks++;
            if (xpos !== 12'd496 || ypos !== 12'd368 || moving !== 1'b0)
                $display("FAIL reset cycle %0d: got x=%0d y=%0d mv=%0b, expected x=496 y=368 mv=0",
                         i, xpos, ypos, moving);
            else n_pass++;
        end
        vblnk = 1'b0;
        rst_n = 1'b1;
        model_reset();
        tick();
        $display("test_reset done");
    endtask

    task automatic test_accel();
        int exp_step[10] = '{1, 1, 1, 1, 2, 2, 2, 2, 3, 3};
        int prev;
        apply_reset();
        for (int i = 0; i < 10; i++) begin
            prev = int'(xpos);
            run_frame(0, 0, 0, 1, 1);
            n_checks++;
            if (int'(xpos) - prev != exp_step[i] || ypos !== 12'd368)
                $display("FAIL accel_step frame %0d: got dx=%0d y=%0d, expected dx=%0d y=368",
                         i, int'(xpos) - prev, ypos, exp_step[i]);
            else n_pass++;
        end
        n_checks++;
        if (xpos !== 12'd514 || moving !== 1'b1)
            $display("FAIL accel_final: got x=%0d mv=%0b, expected x=514 mv=1", xpos, moving);
        else n_pass++;
        run_frame(0, 0, 0, 0, 1);
        n_checks++;
        if (xpos !== 12'd514 || moving !== 1'b0)
            $display("FAIL accel_release: got x=%0d mv=%0b, expected x=514 mv=0", xpos, moving);
        else n_pass++;
        run_frame(0, 0, 0, 1, 2);
        n_checks++;
        if (xpos !== 12'd515 || moving !== 1'b1)
            $display("FAIL accel_restart: got x=%0d mv=%0b, expected x=515 mv=1", xpos, moving);
        else n_pass++;
    endtask

    task automatic test_clamp();
        int guard;
        apply_reset();
        for (int i = 0; i < 400; i++) begin
            run_frame(0, 1, 0, 1, 1 + (i % 3));
            n_checks++;
            if (xpos !== 12'(m_x) || ypos !== 12'(m_y) || moving !== m_moving)
                $display("FAIL clamp_frame %0d: got x=%0d y=%0d mv=%0b, expected x=%0d y=%0d mv=%0b",
                         i, xpos, ypos, moving, m_x, m_y, m_moving);
            else n_pass++;
        end
        n_checks++;
        if (xpos !== 12'd992 || ypos !== 12'd736 || moving !== 1'b0)
            $display("FAIL clamp_corner: got x=%0d y=%0d mv=%0b, expected x=992 y=736 mv=0",
                     xpos, ypos, moving);
        else n_pass++;
        // Three right frames leave x=499, so the left run lands on x=2 at full speed.
        apply_reset();
        for (int i = 0; i < 3; i++) run_frame(0, 0, 0, 1, 1);
        guard = 0;
        while (m_x != 2 && guard < 200) begin
            run_frame(0, 0, 1, 0, 1);
            guard++;
        end
        n_checks++;
        if (xpos !== 12'd2)
            $display("FAIL clamp_left_pre: got x=%0d, expected x=2", xpos);
        else n_pass++;
        run_frame(0, 0, 1, 0, 1);
        n_checks++;
        if (xpos !== 12'd0 || moving !== 1'b1)
            $display("FAIL clamp_left_zero: got x=%0d mv=%0b, expected x=0 mv=1", xpos, moving);
        else n_pass++;
        run_frame(0, 0, 1, 0, 1);
        n_checks++;
        if (xpos !== 12'd0 || moving !== 1'b0)
            $display("FAIL clamp_left_hold: got x=%0d mv=%0b, expected x=0 mv=0", xpos, moving);
        else n_pass++;
    endtask

    task automatic test_cancel();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            run_frame(1, 1, 1, 0, 1);
            n_checks++;
            if (ypos !== 12'd368 || xpos !== 12'(495 - i))
                $display("FAIL cancel frame %0d: got x=%0d y=%0d, expected x=%0d y=368",
                         i, xpos, ypos, 495 - i);
            else n_pass++;
        end
    endtask

    task automatic test_latency();
        apply_reset();
        set_dirs(0, 0, 1, 0);
        repeat (4) tick();
        vblnk = 1'b1;                 // cycle T
        tick();                       // T+1
        n_checks++;
        if (xpos !== 12'd496) $display("FAIL latency_t1: got x=%0d, expected x=496", xpos);
        else n_pass++;
        vblnk = 1'b0;
        tick();                       // T+2: a new rising edge here lands in COMMIT
        n_checks++;
        if (xpos !== 12'd496) $display("FAIL latency_t2: got x=%0d, expected x=496", xpos);
        else n_pass++;
        vblnk = 1'b1;
        tick();                       // T+3
        model_frame(0, 0, 1, 0);
        n_checks++;
        if (xpos !== 12'(m_x) || moving !== 1'b1)
            $display("FAIL latency_t3: got x=%0d mv=%0b, expected x=%0d mv=1", xpos, moving, m_x);
        else n_pass++;
        vblnk = 1'b0;
        repeat (8) tick();
        n_checks++;
        if (xpos !== 12'd495)
            $display("FAIL latency_ignored: got x=%0d, expected x=495", xpos);
        else n_pass++;
        $display("latency pulse: xpos=%0d", xpos);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 0; i < 6; i++) run_frame(0, 0, 0, 1, 1);
        n_checks++;
        if (xpos !== 12'(m_x)) $display("FAIL midrst_pre: got x=%0d, expected x=%0d", xpos, m_x);
        else n_pass++;
        repeat (4) tick();
        vblnk = 1'b1;
        tick();                       // CALC
        vblnk = 1'b0;
        tick();                       // COMMIT
        rst_n = 1'b0;
        tick();
        n_checks++;
        if (xpos !== 12'd496 || ypos !== 12'd368 || moving !== 1'b0)
            $display("FAIL midrst_abort: got x=%0d y=%0d mv=%0b, expected x=496 y=368 mv=0",
                     xpos, ypos, moving);
        else n_pass++;
        rst_n = 1'b1;
        model_reset();
        run_frame(0, 0, 0, 1, 1);
        n_checks++;
        if (xpos !== 12'd497 || moving !== 1'b1)
            $display("FAIL midrst_after: got x=%0d mv=%0b, expected x=497 mv=1", xpos, moving);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [3:0] dirs;
        apply_reset();
        dirs = 4'b0001;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 3) == 0) dirs = 4'($urandom_range(0, 15));
            run_frame(dirs[3], dirs[2], dirs[1], dirs[0], int'($urandom_range(1, 3)));
            n_checks++;
            if (xpos !== 12'(m_x) || ypos !== 12'(m_y) || moving !== m_moving)
                $display("FAIL random frame %0d: got x=%0d y=%0d mv=%0b, expected x=%0d y=%0d mv=%0b",
                         i, xpos, ypos, moving, m_x, m_y, m_moving);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_accel();
        test_clamp();
        test_cancel();
        test_latency();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
